spi_cmd_queue: RTL and testbench

SPI_CMD_QUEUE -- requirements
Module: spi_cmd_queue

---
 rtl/spi_pkg.sv | 16 +
 rtl/spi_cmdq_fifo.sv | 44 ++++
 rtl/spi_cmd_queue.sv | 100 ++++++++++
 tb/tb_spi_cmd_queue.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// spi_pkg: command/response payload types and FSM states shared by the SPI command queue
package spi_pkg;
  typedef struct packed {
    logic       wr;
    logic [7:0] addr;
    logic [7:0] din;
  } cmd_t;
  typedef struct packed {
    logic       wr;
    logic [7:0] rdata;
    logic       err;
    logic       timeout;
  } rsp_t;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  localparam int CMD_W = $bits(cmd_t);
endpackage

// File: rtl/spi_cmdq_fifo.sv
// spi_cmdq_fifo: synchronous command FIFO with registered full/empty
module spi_cmdq_fifo
  import spi_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [CMD_W-1:0] din,
  output logic [CMD_W-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [CMD_W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt, cnt_nx;
  logic do_push, do_pop;
  // full is registered, so a push against a full FIFO is refused even if it pops that cycle
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign cnt_nx = cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
  assign dout = mem[rp];
  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= din;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      full <= 1'b0;
      empty <= 1'b1;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
      cnt <= cnt_nx;
      full <= cnt_nx == (AW+1)'(DEPTH);
      empty <= cnt_nx == '0;
    end
  end
endmodule

// File: rtl/spi_cmd_queue.sv
// spi_cmd_queue: queues host commands and sequences them one at a time through an SPI interface.
// Define SPI_CMDQ_TIMEOUT_EN to bound WAIT by TIMEOUT cycles with a timeout response.
module spi_cmd_queue
  import spi_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_wr,
  input  logic [7:0] cmd_addr,
  input  logic [7:0] cmd_din,
  output logic       spi_rst,
  output logic       spi_wr,
  output logic [7:0] spi_addr,
  output logic [7:0] spi_din,
  input  logic       spi_done,
  input  logic       spi_err,
  input  logic [7:0] spi_dout,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_wr,
  output logic [7:0] rsp_rdata,
  output logic       rsp_err,
  output logic       rsp_timeout
);
  state_t state, state_nx;
  cmd_t iss, head;
  rsp_t rsp;
  logic full, empty, pop, tmo;
  if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_bad_param
    $error("spi_cmd_queue: DEPTH must be a power of two in 2..16 and TIMEOUT >= 1");
  end
  spi_cmdq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (cmd_valid),
    .pop   (pop),
    .din   ({cmd_wr, cmd_addr, cmd_din}),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );
`ifdef SPI_CMDQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] cnt;
  // cnt is 0 on the first WAIT cycle, so TIMEOUT WAIT cycles elapse before RESP
  always_ff @(posedge clk) begin
    if (rst || state == ISSUE) cnt <= '0;
    else if (state == WAIT) cnt <= cnt + 1'b1;
  end
  assign tmo = state == WAIT && cnt == TW'(TIMEOUT - 1);
`else
  assign tmo = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_nx;
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = empty ? IDLE : ISSUE;
      ISSUE:   state_nx = WAIT;
      WAIT:    state_nx = (spi_done || tmo) ? RESP : WAIT;
      RESP:    state_nx = rsp_ready ? IDLE : RESP;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    pop = state == IDLE && !empty;
    spi_rst = !(state == ISSUE || state == WAIT);
    rsp_valid = state == RESP;
  end
  // iss only reloads on a pop in IDLE, keeping the SPI command stable through RESP
  always_ff @(posedge clk) begin
    if (rst) begin
      iss <= '0;
      rsp <= '0;
    end else begin
      if (pop) iss <= head;
      if (state == WAIT && (spi_done || tmo))
        rsp <= '{wr: iss.wr,
                 rdata: (spi_done && !spi_err && !iss.wr) ? spi_dout : 8'h00,
                 err: spi_err || !spi_done,
                 timeout: !spi_done};
    end
  end
  assign cmd_ready = !full;
  assign spi_wr = iss.wr;
  assign spi_addr = iss.addr;
  assign spi_din = iss.din;
  assign rsp_wr = rsp.wr;
  assign rsp_rdata = rsp.rdata;
  assign rsp_err = rsp.err;
  assign rsp_timeout = rsp.timeout;
endmodule

// File: tb/tb_spi_cmd_queue.sv
// tb_spi_cmd_queue: scoreboard bench with a behavioural SPI responder
module tb_spi_cmd_queue;
`ifdef SPI_CMDQ_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 255;
`endif
  logic clk, rst, cmd_valid, cmd_ready, cmd_wr;
  logic [7:0] cmd_addr, cmd_din;
  logic spi_rst, spi_wr, spi_done, spi_err;
  logic [7:0] spi_addr, spi_din, spi_dout;
  logic rsp_valid, rsp_ready, rsp_wr, rsp_err, rsp_timeout;
  logic [7:0] rsp_rdata;
  int checks = 0;
  int failures = 0;
  int lat = (TO > 20) ? 20 : 10;
  logic hang = 1'b0;
  logic [10:0] exp_q[$];

  spi_cmd_queue #(.DEPTH(4), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_wr(cmd_wr), .cmd_addr(cmd_addr), .cmd_din(cmd_din),
    .spi_rst(spi_rst), .spi_wr(spi_wr), .spi_addr(spi_addr), .spi_din(spi_din),
    .spi_done(spi_done), .spi_err(spi_err), .spi_dout(spi_dout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_wr(rsp_wr),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, req);
    end
  endtask

  // Responder: addr 40 errors, reads return addr+A0, hang mode never completes
  function automatic logic [10:0] model(input logic w, input logic [7:0] a);
    logic err;
    err = a == 8'd40;
    if (hang) return {w, 8'h00, 1'b1, 1'b1};
    return {w, (!w && !err) ? a + 8'hA0 : 8'h00, err, 1'b0};
  endfunction

  initial begin : spi_model
    logic [7:0] a, d;
    logic w, stab;
    int n;
    spi_done = 1'b0;
    spi_err = 1'b0;
    spi_dout = 8'h00;
    forever begin
      @(posedge clk); #1;
      if (!spi_rst) begin
        a = spi_addr; d = spi_din; w = spi_wr; stab = 1'b1; n = 0;
        while (!spi_rst && (hang || n < lat)) begin
          @(posedge clk); #1;
          n++;
          if (!spi_rst && {spi_wr, spi_addr, spi_din} != {w, a, d}) stab = 1'b0;
        end
        if (!spi_rst) begin
          spi_done = 1'b1; spi_err = a == 8'd40; spi_dout = a + 8'hA0;
          @(posedge clk); #1;
          check("spi_stable", {31'd0, stab}, 32'd1);
          // stray pulse outside WAIT must not disturb the captured response
          spi_done = 1'b1; spi_err = 1'b1; spi_dout = 8'hFF;
          @(posedge clk); #1;
          spi_done = 1'b0; spi_err = 1'b0; spi_dout = 8'h00;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) check("rsp_unexpected", 32'd1, 32'd0);
      else check("rsp", {21'd0, rsp_wr, rsp_rdata, rsp_err, rsp_timeout}, {21'd0, exp_q.pop_front()});
    end
  end

  task automatic push(input logic w, input logic [7:0] a, input logic [7:0] d);
    int n = 0;
    cmd_valid = 1'b1; cmd_wr = w; cmd_addr = a; cmd_din = d;
    while (!cmd_ready && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    if (!cmd_ready) check("push_timeout", 32'd0, 32'd1);
    else exp_q.push_back(model(w, a));
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    int n = 0;
    while (!rsp_valid && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    if (!rsp_valid) check("rsp_wait_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain", exp_q.size(), 32'd0);
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = 8'h00; cmd_din = 8'h00; rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_spi_rst", {31'd0, spi_rst}, 32'd1);
    check("rst_spi_cmd", {15'd0, spi_wr, spi_addr, spi_din}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_payload", {21'd0, rsp_wr, rsp_rdata, rsp_err, rsp_timeout}, 32'd0);
    rst = 1'b0;

    // write held in RESP, command and payload must stay put
    rsp_ready = 1'b0;
    push(1'b1, 8'd5, 8'hA5);
    wait_rsp();
    repeat (3) @(posedge clk);
    #1;
    check("resp_hold_valid", {31'd0, rsp_valid}, 32'd1);
    check("resp_hold_spi", {15'd0, spi_wr, spi_addr, spi_din}, {15'd0, 1'b1, 8'd5, 8'hA5});
    check("resp_hold_spi_rst", {31'd0, spi_rst}, 32'd1);
    check("resp_hold_payload", {21'd0, rsp_wr, rsp_rdata, rsp_err, rsp_timeout}, {21'd0, 1'b1, 8'h00, 1'b0, 1'b0});
    rsp_ready = 1'b1;
    drain();

    push(1'b0, 8'd5, 8'h00);
    drain();
    push(1'b0, 8'd40, 8'h00);
    drain();

    // FSM parked in RESP, then four pushes fill the FIFO
    rsp_ready = 1'b0;
    push(1'b0, 8'd1, 8'h00);
    wait_rsp();
    push(1'b1, 8'd2, 8'h12);
    push(1'b0, 8'd3, 8'h00);
    push(1'b1, 8'd4, 8'h34);
    check("not_full_after_3", {31'd0, cmd_ready}, 32'd1);
    push(1'b0, 8'd40, 8'h00);
    check("full_after_4", {31'd0, cmd_ready}, 32'd0);
    repeat (4) @(posedge clk);
    #1;
    check("full_held", {31'd0, cmd_ready}, 32'd0);
    rsp_ready = 1'b1;
    push(1'b1, 8'd6, 8'h56);
    drain();

    // reset mid-WAIT with a second command still queued
    hang = 1'b1;
    push(1'b0, 8'd9, 8'h00);
    push(1'b1, 8'd10, 8'h03);
    repeat (4) @(posedge clk);
    #1;
    check("in_wait", {31'd0, spi_rst}, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    hang = 1'b0;
    check("rst_mid_spi_rst", {31'd0, spi_rst}, 32'd1);
    check("rst_mid_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_mid_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    repeat (6) @(posedge clk);
    #1;
    check("rst_fifo_empty", {30'd0, spi_rst, rsp_valid}, {30'd0, 1'b1, 1'b0});
    push(1'b0, 8'd7, 8'h00);
    drain();

`ifdef SPI_CMDQ_TIMEOUT_EN
    begin : timeout_case
      int n = 0;
      hang = 1'b1;
      push(1'b1, 8'd8, 8'h01);
      while (spi_rst && n < 20) begin
        @(posedge clk); #1;
        n++;
      end
      n = 0;
      while (!rsp_valid && n < 100) begin
        @(posedge clk); #1;
        n++;
      end
      check("timeout_latency", n, 32'd17);
      drain();
      hang = 1'b0;
    end
`endif

    repeat (10) @(posedge clk);
    #1;
    check("idle_end", {30'd0, spi_rst, rsp_valid}, {30'd0, 1'b1, 1'b0});
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
